// File: rtl/odd_div_pkg.sv
// Shared definitions for the odd-ratio divided-clock monitor.
//
// Contents:
//   state_e      - monitor FSM states (IDLE, ARM, MEASURE)
//   DIV_DEFAULT  - default expected division ratio
//   HI_MIN       - lowest acceptable high time for DIV_DEFAULT (DIV/2)
//   HI_MAX       - highest acceptable high time for DIV_DEFAULT (DIV/2+1)
//   hi_min/hi_max helpers - the same bounds for any odd ratio
package odd_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int DIV_DEFAULT = 9;

    // An odd divider cannot be exactly 50% duty; either half-split is legal.
    function automatic int hi_min(input int div);
        return div / 2;
    endfunction

    function automatic int hi_max(input int div);
        return div / 2 + 1;
    endfunction

    localparam int HI_MIN = DIV_DEFAULT / 2;
    localparam int HI_MAX = DIV_DEFAULT / 2 + 1;

endpackage

// File: rtl/div_sync_edge.sv
// Synchronizer and rising-edge detector for the divided clock under test.
//
// Ports:
//   clk_i    in  1  sampling clock
//   rstn_i   in  1  asynchronous active-low reset
//   d_i      in  1  asynchronous input (divided clock)
//   sync_o   out 1  synchronized level (last synchronizer stage)
//   rise_o   out 1  synchronized level went 0->1 on the last clock edge
module div_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    // prev_q resets low, so a level already high at reset release counts as a rise.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/odd_div_monitor.sv
// Receive-side health monitor for an odd-ratio divided clock.
// Measures period and high time (in clk cycles) between synchronized rising
// edges of clk_div_in, flags period/duty errors and reports lock after
// LOCK_CNT consecutive good measurements.
//
// Ports:
//   clk         in  1   reference clock, rising edge
//   rstn        in  1   asynchronous active-low reset
//   en          in  1   monitor enable; low forces IDLE
//   clk_div_in  in  1   divided clock under test (asynchronous)
//   period      out CW  last measured period
//   high_time   out CW  last measured high time
//   meas_valid  out 1   one-cycle strobe when period/high_time update
//   locked      out 1   LOCK_CNT consecutive good measurements seen
//   err_period  out 1   one-cycle strobe: period != DIV, or counter saturated
//   err_duty    out 1   one-cycle strobe: high time outside {DIV/2, DIV/2+1}
//   dbg_state   out 2   current FSM state (state_e encoding)
//
// Strobe semantics: meas_valid, err_period and err_duty are single-cycle
// pulses with no back-pressure; a consumer that needs them must sample every
// cycle. period/high_time are stable from one meas_valid to the next.
module odd_div_monitor
    import odd_div_pkg::*;
#(
    parameter int DIV         = DIV_DEFAULT,
    parameter int CW          = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          clk_div_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          meas_valid,
    output logic          locked,
    output logic          err_period,
    output logic          err_duty,
    output logic [1:0]    dbg_state
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] DIV_C    = CW'(DIV);
    localparam logic [CW-1:0] HI_MIN_C = CW'(hi_min(DIV));
    localparam logic [CW-1:0] HI_MAX_C = CW'(hi_max(DIV));
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_CNT);

    logic sync_out;
    logic rise;

    div_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rstn_i(rstn),
        .d_i   (clk_div_in),
        .sync_o(sync_out),
        .rise_o(rise)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_time_q, high_time_d;
    logic          meas_valid_q, meas_valid_d;
    logic          err_period_q, err_period_d;
    logic          err_duty_q, err_duty_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            err_period_q <= 1'b0;
            err_duty_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            err_period_q <= err_period_d;
            err_duty_q   <= err_duty_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        err_period_d = 1'b0;
        err_duty_d   = 1'b0;

        if (!en) begin
            // Disabling abandons any partial period silently; a rise seen in
            // this same cycle is dropped too.
            state_d    = IDLE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            good_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d  = '0;
                    hi_cnt_d   = '0;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                    state_d    = ARM;
                end

                ARM: begin
                    // First rise only establishes the phase reference.
                    if (rise) begin
                        per_cnt_d = CW'(1);
                        hi_cnt_d  = CW'(1);
                        state_d   = MEASURE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        period_d     = per_cnt_q;
                        high_time_d  = hi_cnt_q;
                        meas_valid_d = 1'b1;
                        err_period_d = (per_cnt_q != DIV_C);
                        err_duty_d   = (hi_cnt_q != HI_MIN_C) && (hi_cnt_q != HI_MAX_C);
                        if (err_period_d || err_duty_d) begin
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else begin
                            if (good_cnt_q != LOCK_C) begin
                                good_cnt_d = good_cnt_q + GW'(1);
                            end
                            if (good_cnt_d == LOCK_C) begin
                                locked_d = 1'b1;
                            end
                        end
                        // The rise cycle itself is the first cycle (and first
                        // high cycle) of the next period.
                        per_cnt_d = CW'(1);
                        hi_cnt_d  = CW'(1);
                    end else if (per_cnt_q == CNT_MAX) begin
                        // Stuck input: give up on this period and re-arm
                        // without publishing a measurement.
                        err_period_d = 1'b1;
                        good_cnt_d   = '0;
                        locked_d     = 1'b0;
                        per_cnt_d    = '0;
                        hi_cnt_d     = '0;
                        state_d      = ARM;
                    end else begin
                        per_cnt_d = per_cnt_q + CW'(1);
                        if (sync_out) begin
                            hi_cnt_d = hi_cnt_q + CW'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err_period = err_period_q;
    assign err_duty   = err_duty_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_odd_div_monitor.sv
// Self-checking bench for odd_div_monitor (DIV=9, CW=8, LOCK_CNT=4, SYNC_STAGES=2).
// A waveform-level reference model predicts every output on every cycle from
// the recorded input samples; table vectors and hand sequences add targeted
// checks of the captured measurements.
module tb_odd_div_monitor;
    import odd_div_pkg::*;

    localparam int DIV         = 9;
    localparam int CW          = 8;
    localparam int LOCK_CNT    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_MAX     = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk        = 1'b0;
    logic          rstn       = 1'b1;
    logic          en         = 1'b0;
    logic          clk_div_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          err_period;
    logic          err_duty;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    odd_div_monitor #(
        .DIV        (DIV),
        .CW         (CW),
        .LOCK_CNT   (LOCK_CNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clk_div_in(clk_div_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .err_period(err_period),
        .err_duty  (err_duty),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // samp_q[t] is clk_div_in as seen at the t-th clock edge since reset release.
    bit samp_q[$];
    int m_mode;     // 0 = disabled, 1 = waiting for reference rise, 2 = measuring
    int m_last;     // edge index at which the current period began
    int m_good;
    int m_period;
    int m_high;
    bit m_mv;
    bit m_ep;
    bit m_ed;

    function automatic int samp_at(input int j);
        if (j < 0 || j >= samp_q.size()) return 0;
        return int'(samp_q[j]);
    endfunction

    task automatic model_reset();
        samp_q.delete();
        m_mode = 0; m_last = 0; m_good = 0;
        m_period = 0; m_high = 0;
        m_mv = 0; m_ep = 0; m_ed = 0;
    endtask

    // The DUT sees a rise at edge t when the sample SYNC_STAGES edges earlier
    // is high and the one before it low; the period is the distance between
    // such edges and the high time is the number of high samples in between.
    task automatic model_edge();
        int t;
        int hi;
        bit rise;
        t = samp_q.size();
        samp_q.push_back(clk_div_in);
        rise = (samp_at(t - SYNC_STAGES) == 1) && (samp_at(t - SYNC_STAGES - 1) == 0);
        m_mv = 0; m_ep = 0; m_ed = 0;
        if (!en) begin
            m_mode = 0;
            m_good = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rise) begin
                m_mode = 2;
                m_last = t;
            end
        end else if (rise) begin
            hi = 0;
            for (int u = m_last; u < t; u++) hi += samp_at(u - SYNC_STAGES);
            m_period = t - m_last;
            m_high   = hi;
            m_mv     = 1;
            m_ep     = (m_period != DIV);
            m_ed     = !(hi == DIV / 2 || hi == DIV / 2 + 1);
            if (m_ep || m_ed) m_good = 0;
            else if (m_good < LOCK_CNT) m_good++;
            m_last = t;
        end else if (t - m_last == CNT_MAX) begin
            m_ep   = 1;
            m_good = 0;
            m_mode = 1;
        end
    endtask

    // ---------------- captures for directed checks ----------------
    int cap_mv, cap_ep, cap_ed, cap_period, cap_high;

    task automatic clr_cap();
        cap_mv = 0; cap_ep = 0; cap_ed = 0; cap_period = -1; cap_high = -1;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model the edge, then compare every output half a cycle later.
    task automatic step();
        state_e exp_state;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_state = (m_mode == 0) ? IDLE : (m_mode == 1) ? ARM : MEASURE;
        chk("period",     int'(period),     m_period);
        chk("high_time",  int'(high_time),  m_high);
        chk("meas_valid", int'(meas_valid), int'(m_mv));
        chk("err_period", int'(err_period), int'(m_ep));
        chk("err_duty",   int'(err_duty),   int'(m_ed));
        chk("locked",     int'(locked),     (m_good == LOCK_CNT) ? 1 : 0);
        chk("state",      int'(dbg_state),  int'(exp_state));
        if (meas_valid) begin
            cap_mv++;
            cap_period = int'(period);
            cap_high   = int'(high_time);
        end
        if (err_period) cap_ep++;
        if (err_duty)   cap_ed++;
    endtask

    task automatic hold(input bit v, input int n);
        clk_div_in = v;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse(input int h, input int l);
        hold(1'b1, h);
        hold(1'b0, l);
    endtask

    // Asserts reset right away (caller is between edges) and checks that the
    // outputs clear without waiting for a clock edge.
    task automatic do_reset();
        rstn = 1'b0;
        en = 1'b0;
        clk_div_in = 1'b0;
        #1;
        chk("rst_period",     int'(period),     0);
        chk("rst_high_time",  int'(high_time),  0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_locked",     int'(locked),     0);
        chk("rst_err_period", int'(err_period), 0);
        chk("rst_err_duty",   int'(err_duty),   0);
        chk("rst_state",      int'(dbg_state),  int'(IDLE));
        model_reset();
        clr_cap();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int h;          // high cycles per period
        int l;          // low cycles per period
        int n;          // periods measured
        int e_period;
        int e_high;
        int e_ep;       // err_period expected on every measurement
        int e_ed;       // err_duty expected on every measurement
        int e_locked;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = '{4, 5, 6, 9, 4, 0, 0, 1};
        vecs[1] = '{5, 4, 6, 9, 5, 0, 0, 1};
        vecs[2] = '{2, 7, 5, 9, 2, 0, 1, 0};
        vecs[3] = '{4, 6, 3, 10, 4, 1, 0, 0};
        vecs[4] = '{3, 5, 3, 8, 3, 1, 1, 0};
        vecs[5] = '{6, 3, 3, 9, 6, 0, 1, 0};

        #2;
        do_reset();

        // Table: a steady waveform from reset, closed by one trailing rise.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            en = 1'b1;
            hold(1'b0, 2);
            repeat (vecs[i].n) pulse(vecs[i].h, vecs[i].l);
            hold(1'b1, vecs[i].h);
            hold(1'b0, SYNC_STAGES + 2);
            chk("tbl_nmeas",  cap_mv,     vecs[i].n);
            chk("tbl_period", cap_period, vecs[i].e_period);
            chk("tbl_high",   cap_high,   vecs[i].e_high);
            chk("tbl_ep_cnt", cap_ep,     vecs[i].e_ep * vecs[i].n);
            chk("tbl_ed_cnt", cap_ed,     vecs[i].e_ed * vecs[i].n);
            chk("tbl_locked", int'(locked), vecs[i].e_locked);
        end

        // Lock, one 10-cycle period, then relock after four good periods.
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        repeat (6) pulse(4, 5);
        chk("t2_locked_before", int'(locked), 1);
        clr_cap();
        pulse(4, 6);
        hold(1'b1, 4);
        chk("t2_ep_cnt",     cap_ep,       1);
        chk("t2_period",     cap_period,   10);
        chk("t2_locked_drop", int'(locked), 0);
        hold(1'b0, 5);
        repeat (3) pulse(4, 5);
        chk("t2_not_yet",    int'(locked), 0);
        pulse(4, 5);
        chk("t2_relocked",   int'(locked), 1);

        // Stuck-low input while measuring.
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        repeat (5) pulse(4, 5);
        clr_cap();
        hold(1'b1, 4);
        hold(1'b0, 300);
        chk("t4_meas_cnt",   cap_mv,       1);
        chk("t4_ep_cnt",     cap_ep,       1);
        chk("t4_state_arm",  int'(dbg_state), int'(ARM));
        chk("t4_locked",     int'(locked), 0);
        clr_cap();
        pulse(4, 5);
        hold(1'b1, 4);
        hold(1'b0, 4);
        chk("t4_after_meas", cap_mv,       1);
        chk("t4_after_per",  cap_period,   9);
        chk("t4_after_ep",   cap_ep,       0);

        // Enable dropped mid-period, then restored.
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        repeat (3) pulse(4, 5);
        hold(1'b1, 4);
        hold(1'b0, 2);
        en = 1'b0;
        clr_cap();
        hold(1'b0, 3);
        en = 1'b1;
        hold(1'b0, 2);
        pulse(4, 5);
        chk("t5_first_rise_mv", cap_mv, 0);
        chk("t5_no_err", cap_ep + cap_ed, 0);
        hold(1'b1, 4);
        hold(1'b0, 4);
        chk("t5_second_mv",  cap_mv,     1);
        chk("t5_period",     cap_period, 9);

        // Reset while locked, then a normal run from reset.
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        repeat (6) pulse(4, 5);
        chk("t6_locked", int'(locked), 1);
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        repeat (6) pulse(4, 5);
        chk("t6_relock", int'(locked), 1);

        // Random waveforms, enable drops and stuck periods against the model.
        do_reset();
        en = 1'b1;
        hold(1'b0, 2);
        for (int it = 0; it < 200; it++) begin
            int h, l, r;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                h = DIV / 2; l = DIV - h;
            end else if (r < 60) begin
                h = DIV / 2 + 1; l = DIV - h;
            end else begin
                h = $urandom_range(1, 9); l = $urandom_range(1, 9);
            end
            pulse(h, l);
            r = $urandom_range(0, 99);
            if (r < 5) begin
                en = 1'b0;
                hold(1'b0, $urandom_range(1, 6));
                en = 1'b1;
            end else if (r < 9) begin
                en = 1'b0;
                hold(1'b1, $urandom_range(1, 3));
                en = 1'b1;
            end else if (r < 11) begin
                hold(1'b0, $urandom_range(250, 300));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
